// File: rtl/stump_bist_ctrl.sv
// BIST sequencer for the STUMPS datapath: PRPG seed load, scan shift and capture per pattern,
// a final scan unload into the SISA, then a signature compare against golden_sig.
module stump_bist_ctrl #(
    parameter int CHAIN_LEN   = 16,
    parameter int PATTERN_CNT = 1024,
    parameter int SIG_W       = 181
) (
    input  logic                               clk,
    input  logic                               internalRst,
    input  logic                               start,
    input  logic                               abort,
    input  logic [SIG_W-1:0]                   sisa_sig,
    input  logic [SIG_W-1:0]                   golden_sig,
    output logic                               seed_load,
    output logic                               prpg_en,
    output logic                               scan_en,
    output logic                               capture,
    output logic                               sisa_en,
    output logic [$clog2(PATTERN_CNT+1)-1:0]   pattern_idx,
    output logic                               busy,
    output logic                               done,
    output logic                               pass
);

    localparam int PW = $clog2(PATTERN_CNT + 1);
    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   shift_cnt_q, shift_cnt_d;
    logic [PW-1:0]   pattern_idx_q, pattern_idx_d;
    logic            pass_q, pass_d;
    logic            busy_state;
    logic            shift_last;

    always_ff @(posedge clk or posedge internalRst) begin
        if (internalRst) begin
            state_q       <= IDLE;
            shift_cnt_q   <= '0;
            pattern_idx_q <= '0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_cnt_q   <= shift_cnt_d;
            pattern_idx_q <= pattern_idx_d;
            pass_q        <= pass_d;
        end
    end

    assign busy_state = (state_q == INIT) || (state_q == SHIFT) || (state_q == CAPTURE) ||
                        (state_q == UNLOAD) || (state_q == COMPARE);
    assign shift_last = (shift_cnt_q == CW'(CHAIN_LEN - 1));

    always_comb begin
        state_d       = state_q;
        shift_cnt_d   = shift_cnt_q;
        pattern_idx_d = pattern_idx_q;
        pass_d        = pass_q;
        if (abort && busy_state) begin
            state_d       = IDLE;
            shift_cnt_d   = '0;
            pattern_idx_d = '0;
            pass_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // Restart clears the previous verdict on the accepting edge
                    if (start) begin
                        state_d       = INIT;
                        pattern_idx_d = '0;
                        pass_d        = 1'b0;
                    end
                end
                INIT: begin
                    state_d       = SHIFT;
                    shift_cnt_d   = '0;
                    pattern_idx_d = '0;
                end
                SHIFT: begin
                    if (shift_last) begin
                        shift_cnt_d = '0;
                        state_d     = CAPTURE;
                    end else begin
                        shift_cnt_d = shift_cnt_q + CW'(1);
                    end
                end
                CAPTURE: begin
                    pattern_idx_d = pattern_idx_q + PW'(1);
                    state_d       = (pattern_idx_q == PW'(PATTERN_CNT - 1)) ? UNLOAD : SHIFT;
                end
                UNLOAD: begin
                    if (shift_last) begin
                        shift_cnt_d = '0;
                        state_d     = COMPARE;
                    end else begin
                        shift_cnt_d = shift_cnt_q + CW'(1);
                    end
                end
                COMPARE: begin
                    pass_d  = (sisa_sig == golden_sig);
                    state_d = DONE;
                end
                default: begin
                    state_d     = IDLE;
                    shift_cnt_d = '0;
                end
            endcase
        end
    end

    // The first SHIFT after INIT unloads undefined chain content, so the SISA skips it;
    // pattern_idx is still 0 only during that first shift phase.
    always_comb begin
        seed_load   = (state_q == INIT);
        prpg_en     = (state_q == SHIFT);
        scan_en     = (state_q == SHIFT) || (state_q == UNLOAD);
        capture     = (state_q == CAPTURE);
        sisa_en     = ((state_q == SHIFT) && (pattern_idx_q != '0)) || (state_q == UNLOAD);
        pattern_idx = pattern_idx_q;
        busy        = busy_state;
        done        = (state_q == DONE);
        pass        = pass_q && (state_q == DONE);
    end

endmodule

// File: tb/tb_stump_bist_ctrl.sv
// Directed bench for stump_bist_ctrl: a CHAIN_LEN=4/PATTERN_CNT=3 instance for the main scenarios
// and a CHAIN_LEN=1/PATTERN_CNT=1 instance for the minimal configuration.
module tb_stump_bist_ctrl;

    localparam int C = 4;
    localparam int P = 3;
    localparam int W = 181;

    logic         clk = 1'b0;
    logic         internalRst;
    logic         start, abort;
    logic [W-1:0] sisa_sig, golden_sig;
    logic         seed_load, prpg_en, scan_en, capture, sisa_en, busy, done, pass;
    logic [1:0]   pattern_idx;

    logic         start_b, abort_b;
    logic         seed_load_b, prpg_en_b, scan_en_b, capture_b, sisa_en_b, busy_b, done_b, pass_b;
    logic [0:0]   pattern_idx_b;

    int total = 0;
    int bad   = 0;

    int n_seed, n_cap, n_sisa, n_prpg, first_done;
    int cap_pos [3];

    always #5 clk = ~clk;

    stump_bist_ctrl #(.CHAIN_LEN(C), .PATTERN_CNT(P), .SIG_W(W)) dut (
        .clk(clk), .internalRst(internalRst), .start(start), .abort(abort),
        .sisa_sig(sisa_sig), .golden_sig(golden_sig),
        .seed_load(seed_load), .prpg_en(prpg_en), .scan_en(scan_en), .capture(capture),
        .sisa_en(sisa_en), .pattern_idx(pattern_idx), .busy(busy), .done(done), .pass(pass)
    );

    stump_bist_ctrl #(.CHAIN_LEN(1), .PATTERN_CNT(1), .SIG_W(W)) dut_b (
        .clk(clk), .internalRst(internalRst), .start(start_b), .abort(abort_b),
        .sisa_sig(sisa_sig), .golden_sig(sisa_sig),
        .seed_load(seed_load_b), .prpg_en(prpg_en_b), .scan_en(scan_en_b), .capture(capture_b),
        .sisa_en(sisa_en_b), .pattern_idx(pattern_idx_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    function automatic logic [7:0] outs_a();
        return {seed_load, scan_en, prpg_en, sisa_en, capture, busy, done, pass};
    endfunction

    // e counts clock edges after the accepting edge; samples are taken on the falling edge.
    task automatic measure(input int budget);
        n_seed = 0; n_cap = 0; n_sisa = 0; n_prpg = 0; first_done = -1;
        for (int e = 0; e < budget; e++) begin
            @(negedge clk);
            if (seed_load) n_seed++;
            if (capture) begin
                if (n_cap < 3) cap_pos[n_cap] = e;
                n_cap++;
            end
            if (sisa_en) n_sisa++;
            if (prpg_en) n_prpg++;
            if (done) begin
                first_done = e;
                break;
            end
        end
    endtask

    task automatic launch(input logic hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (outs_a() !== 8'h00 || pattern_idx !== 2'd0) begin
            bad++;
            $display("FAIL reset_hold: outs=%b idx=%0d want outs=00000000 idx=0", outs_a(), pattern_idx);
        end
        internalRst = 1'b0;
        @(negedge clk);
        total++;
        if (outs_a() !== 8'h00) begin
            bad++;
            $display("FAIL reset_release_idle: outs=%b want 00000000", outs_a());
        end
    endtask

    task automatic test_match();
        golden_sig = sisa_sig;
        launch(1'b0);
        measure(40);
        $display("match run: done at edge %0d, seeds=%0d caps=%0d sisa_en=%0d prpg_en=%0d pass=%0b",
                 first_done, n_seed, n_cap, n_sisa, n_prpg, pass);
        total++;
        if (first_done != 21) begin bad++; $display("FAIL match_done_edge: got %0d want 21", first_done); end
        total++;
        if (n_seed != 1) begin bad++; $display("FAIL match_seed_count: got %0d want 1", n_seed); end
        total++;
        if (n_cap != 3 || cap_pos[0] != 5 || cap_pos[1] != 10 || cap_pos[2] != 15) begin
            bad++;
            $display("FAIL match_captures: count=%0d at %0d,%0d,%0d want 3 at 5,10,15",
                     n_cap, cap_pos[0], cap_pos[1], cap_pos[2]);
        end
        total++;
        if (n_sisa != 12 || n_prpg != 12) begin
            bad++;
            $display("FAIL match_enable_counts: sisa_en=%0d prpg_en=%0d want 12 and 12", n_sisa, n_prpg);
        end
        total++;
        if (pass !== 1'b1 || pattern_idx !== 2'd3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL match_result: pass=%b idx=%0d busy=%b want 1,3,0", pass, pattern_idx, busy);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("abort in DONE: done=%b pass=%b", done, pass);
        total++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_done_ignored: done=%b pass=%b want 1,1", done, pass);
        end
    endtask

    task automatic test_mismatch();
        golden_sig = sisa_sig ^ {{(W-1){1'b0}}, 1'b1};
        launch(1'b0);
        measure(40);
        $display("mismatch run: done at edge %0d pass=%0b", first_done, pass);
        total++;
        if (first_done != 21 || done !== 1'b1 || pass !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_result: edge=%0d done=%b pass=%b want 21,1,0", first_done, done, pass);
        end
        golden_sig = sisa_sig;
    endtask

    task automatic test_abort();
        launch(1'b0);
        for (int e = 0; e <= 7; e++) @(negedge clk);
        total++;
        if (scan_en !== 1'b1 || prpg_en !== 1'b1 || sisa_en !== 1'b1 || pattern_idx !== 2'd1) begin
            bad++;
            $display("FAIL abort_second_shift: scan=%b prpg=%b sisa=%b idx=%0d want 1,1,1,1",
                     scan_en, prpg_en, sisa_en, pattern_idx);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        $display("abort in SHIFT: outs=%b idx=%0d", outs_a(), pattern_idx);
        total++;
        if (outs_a() !== 8'h00 || pattern_idx !== 2'd0) begin
            bad++;
            $display("FAIL abort_to_idle: outs=%b idx=%0d want 00000000 idx=0", outs_a(), pattern_idx);
        end
        launch(1'b0);
        measure(40);
        $display("rerun after abort: done at edge %0d pass=%0b sisa_en=%0d", first_done, pass, n_sisa);
        total++;
        if (first_done != 21 || pass !== 1'b1 || n_sisa != 12) begin
            bad++;
            $display("FAIL abort_rerun: edge=%0d pass=%b sisa_en=%0d want 21,1,12", first_done, pass, n_sisa);
        end
    endtask

    task automatic test_start_held();
        launch(1'b1);
        measure(40);
        $display("start held: done at edge %0d seeds=%0d", first_done, n_seed);
        total++;
        if (first_done != 21 || n_seed != 1) begin
            bad++;
            $display("FAIL held_start_ignored: edge=%0d seeds=%0d want 21,1", first_done, n_seed);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || pass !== 1'b0 || seed_load !== 1'b1 || pattern_idx !== 2'd0) begin
            bad++;
            $display("FAIL held_restart: done=%b pass=%b seed=%b idx=%0d want 0,0,1,0",
                     done, pass, seed_load, pattern_idx);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL held_cleanup_abort: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_shift();
        launch(1'b0);
        for (int e = 0; e <= 2; e++) @(negedge clk);
        total++;
        if (scan_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_precondition: scan=%b busy=%b want 1,1", scan_en, busy);
        end
        #2 internalRst = 1'b1;
        #1;
        $display("reset mid-shift: outs=%b idx=%0d", outs_a(), pattern_idx);
        total++;
        if (outs_a() !== 8'h00 || pattern_idx !== 2'd0) begin
            bad++;
            $display("FAIL rst_async_clear: outs=%b idx=%0d want 00000000 idx=0", outs_a(), pattern_idx);
        end
        @(negedge clk);
        internalRst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_stays_idle: busy=%b done=%b want 0,0", busy, done);
        end
    endtask

    task automatic test_min_config();
        logic [6:0] exp_tab [6];
        logic [6:0] got;
        // {seed_load, scan_en, prpg_en, sisa_en, capture, busy, done}
        exp_tab[0] = 7'b1000010;
        exp_tab[1] = 7'b0110010;
        exp_tab[2] = 7'b0000110;
        exp_tab[3] = 7'b0101010;
        exp_tab[4] = 7'b0000010;
        exp_tab[5] = 7'b0000001;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            got = {seed_load_b, scan_en_b, prpg_en_b, sisa_en_b, capture_b, busy_b, done_b};
            $display("min config edge %0d: outs=%b", e, got);
            total++;
            if (got !== exp_tab[e]) begin
                bad++;
                $display("FAIL min_seq_edge%0d: got %b want %b", e, got, exp_tab[e]);
            end
        end
        total++;
        if (pass_b !== 1'b1 || pattern_idx_b !== 1'b1) begin
            bad++;
            $display("FAIL min_result: pass=%b idx=%0d want 1,1", pass_b, pattern_idx_b);
        end
    endtask

    initial begin
        internalRst = 1'b1;
        start = 1'b0; abort = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        sisa_sig = '0;
        sisa_sig[63:0]    = 64'hDEAD_BEEF_0123_4567;
        sisa_sig[180:150] = 31'h5A5A_1234;
        golden_sig = sisa_sig;
        test_reset();
        test_match();
        test_mismatch();
        test_abort();
        test_start_held();
        test_reset_mid_shift();
        test_min_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
